// File: rtl/selector_pkg.sv
// selector_pkg: shared state encoding, channel sizing and priority helper for the selector scan controller
package selector_pkg;
  localparam int CHAN_W = 2;
  localparam int NUM_CHAN = 4;
  typedef enum logic {IDLE = 1'b0, DWELL = 1'b1} state_t;
  function automatic logic [CHAN_W-1:0] lowest_set(input logic [NUM_CHAN-1:0] mask);
    return mask[0] ? 2'd0 : mask[1] ? 2'd1 : mask[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/selector41_next_chan.sv
// selector41_next_chan: picks the next enabled channel above the current one, wrapping to the lowest enabled
module selector41_next_chan
  import selector_pkg::*;
(
  input  logic [CHAN_W-1:0]   chan,
  input  logic [NUM_CHAN-1:0] mask,
  output logic [CHAN_W-1:0]   nxt_chan,
  output logic                wrap,
  output logic                no_chan
);
  logic [NUM_CHAN-1:0] hi;
  assign hi = mask & (4'hE << chan);
  assign nxt_chan = (hi != '0) ? lowest_set(hi) : lowest_set(mask);
  assign wrap = (hi == '0) && (mask != '0);
  assign no_chan = (mask == '0);
endmodule

// File: rtl/selector41_scan_ctrl.sv
// selector41_scan_ctrl: steps the 4:1 selector through enabled channels, holding each for a programmable dwell
module selector41_scan_ctrl
  import selector_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iStart,
  input  logic               iStop,
  input  logic               iMode,
  input  logic [DWELL_W-1:0] iDwell,
  input  logic [3:0]         iMask,
  output logic               oS1,
  output logic               oS0,
  output logic               oValid,
  output logic               oFirst,
  output logic               oFrameDone,
  output logic               oBusy
);
  state_t state, state_d;
  logic [CHAN_W-1:0] chan, chan_d, nxt_chan;
  logic [DWELL_W-1:0] cnt, cnt_d, reload;
  logic first, first_d, done, done_d, wrap, no_chan;
  selector41_next_chan u_next (
    .chan(chan),
    .mask(iMask),
    .nxt_chan(nxt_chan),
    .wrap(wrap),
    .no_chan(no_chan)
  );
  // counter holds remaining cycles minus one, so a zero dwell behaves as one
  assign reload = (iDwell == '0) ? '0 : iDwell - 1'b1;
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
      chan <= '0;
      cnt <= '0;
      first <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      chan <= chan_d;
      cnt <= cnt_d;
      first <= first_d;
      done <= done_d;
    end
  end
  always_comb begin
    state_d = state;
    chan_d = chan;
    cnt_d = cnt;
    first_d = 1'b0;
    done_d = 1'b0;
    if (state == IDLE) begin
      if (iStart && !iStop && iMask != '0) begin
        state_d = DWELL;
        chan_d = lowest_set(iMask);
        cnt_d = reload;
        first_d = 1'b1;
      end
    end else if (iStop) begin
      state_d = IDLE;
    end else if (cnt != '0) begin
      cnt_d = cnt - 1'b1;
    end else if (no_chan || (wrap && iMode)) begin
      state_d = IDLE;
      done_d = 1'b1;
    end else begin
      chan_d = nxt_chan;
      cnt_d = reload;
      first_d = 1'b1;
      done_d = wrap;
    end
  end
  assign {oS1, oS0} = chan;
  assign oValid = (state == DWELL);
  assign oBusy = (state == DWELL);
  assign oFirst = first;
  assign oFrameDone = done;
endmodule

// File: tb/tb_selector41_scan_ctrl.sv
// tb_selector41_scan_ctrl: directed and random stimulus checked every cycle against a behavioural scan model
module tb_selector41_scan_ctrl;
  logic iCLK = 1'b0, iRST_N = 1'b0, iStart = 1'b0, iStop = 1'b0, iMode = 1'b0;
  logic [7:0] iDwell = 8'd1;
  logic [3:0] iMask = 4'h0;
  logic oS1, oS0, oValid, oFirst, oFrameDone, oBusy;
  int checks = 0, errors = 0;
  bit cmp_en = 0;
  bit m_run, m_first, m_done;
  int m_ch, m_left;

  selector41_scan_ctrl #(.DWELL_W(8)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iStart(iStart), .iStop(iStop), .iMode(iMode),
    .iDwell(iDwell), .iMask(iMask), .oS1(oS1), .oS0(oS0), .oValid(oValid),
    .oFirst(oFirst), .oFrameDone(oFrameDone), .oBusy(oBusy)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int low(input logic [3:0] m);
    int r = 0;
    for (int c = 3; c >= 0; c--) if (m[c]) r = c;
    return r;
  endfunction

  function automatic int dw();
    return (iDwell == 0) ? 1 : int'(iDwell);
  endfunction

  task automatic model_reset();
    m_run = 0; m_first = 0; m_done = 0; m_ch = 0; m_left = 0;
  endtask

  // m_left counts the cycles still to be spent on the current channel, including this one
  task automatic model_step();
    m_first = 0;
    m_done = 0;
    if (!m_run) begin
      if (iStart && !iStop && iMask != 0) begin
        m_run = 1; m_ch = low(iMask); m_left = dw(); m_first = 1;
      end
    end else if (iStop) begin
      m_run = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        int n = -1;
        for (int c = 3; c > m_ch; c--) if (iMask[c]) n = c;
        if (n >= 0) begin
          m_ch = n; m_left = dw(); m_first = 1;
        end else begin
          m_done = 1;
          if (iMask == 0 || iMode) m_run = 0;
          else begin
            m_ch = low(iMask); m_left = dw(); m_first = 1;
          end
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge iCLK);
    if (iRST_N) model_step();
    #1;
  endtask

  task automatic go_idle();
    iStart = 0; iStop = 1; cyc(); iStop = 0;
  endtask

  always @(negedge iCLK) if (cmp_en) begin
    chk("sel", {oS1, oS0}, m_ch % 4);
    chk("valid", oValid, m_run);
    chk("busy", oBusy, m_run);
    chk("first", oFirst, m_first);
    chk("frame_done", oFrameDone, m_done);
  end

  initial begin
    bit hit;
    model_reset();
    repeat (2) @(posedge iCLK);
    #2 iRST_N = 1;
    cmp_en = 1;
    cyc();
    chk("rst_busy", oBusy, 0);
    chk("rst_sel", {oS1, oS0}, 0);

    // basic single frame: 3 cycles per channel, done on the 13th edge
    iMask = 4'hF; iDwell = 3; iMode = 1; iStart = 1;
    cyc(); iStart = 0;
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) cyc();
      chk("basic_sel", {oS1, oS0}, (i < 12) ? i / 3 : 3);
      chk("basic_valid", oValid, i < 12);
      chk("basic_first", oFirst, (i < 12) && (i % 3 == 0));
      chk("basic_done", oFrameDone, i == 12);
    end

    // skipping in continuous mode
    iMask = 4'b1010; iDwell = 2; iMode = 0; iStart = 1;
    cyc(); iStart = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) cyc();
      chk("skip_sel", {oS1, oS0}, ((i / 2) % 2 == 0) ? 1 : 3);
      chk("skip_first", oFirst, i % 2 == 0);
      chk("skip_done", oFrameDone, (i > 0) && (i % 4 == 0));
    end
    go_idle();
    chk("stop_idle", oBusy, 0);

    // dwell of zero behaves as one
    iMask = 4'b0110; iDwell = 0; iStart = 1;
    cyc(); iStart = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      chk("dw0_sel", {oS1, oS0}, (i % 2 == 0) ? 1 : 2);
      chk("dw0_first", oFirst, 1);
      chk("dw0_done", oFrameDone, (i > 0) && (i % 2 == 0));
    end
    go_idle();

    // stop together with start while on channel 1
    iMask = 4'hF; iDwell = 4; iStart = 1;
    cyc(); iStart = 0;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc();
      hit = (m_ch == 1) && m_run;
    end
    chk("stop_reach_ch1", hit, 1);
    iStop = 1; iStart = 1;
    cyc();
    chk("stop_valid", oValid, 0);
    chk("stop_done", oFrameDone, 0);
    chk("stop_busy", oBusy, 0);
    iStop = 0; iStart = 0;
    cyc();
    chk("stop_norestart", oBusy, 0);

    // mask cleared mid-dwell on channel 1
    iMask = 4'hF; iDwell = 4; iMode = 0; iStart = 1;
    cyc(); iStart = 0;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc();
      hit = (m_ch == 1) && m_first;
    end
    chk("dyn_reach_ch1", hit, 1);
    iMask = 4'h0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("dyn_hold_sel", {oS1, oS0}, 1);
      chk("dyn_hold_valid", oValid, 1);
    end
    cyc();
    chk("dyn_done", oFrameDone, 1);
    chk("dyn_valid", oValid, 0);

    // asynchronous reset in the middle of a scan on channel 2
    iMask = 4'hF; iDwell = 3; iMode = 0; iStart = 1;
    cyc(); iStart = 0;
    repeat (6) cyc();
    chk("rst_pre_ch", {oS1, oS0}, 2);
    #2 iRST_N = 0;
    model_reset();
    #1;
    chk("arst_sel", {oS1, oS0}, 0);
    chk("arst_valid", oValid, 0);
    chk("arst_first", oFirst, 0);
    chk("arst_done", oFrameDone, 0);
    chk("arst_busy", oBusy, 0);
    cyc();
    #2 iRST_N = 1;
    cyc();
    chk("arst_idle", oBusy, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      iStart = ($urandom_range(0, 7) == 0);
      iStop = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 15) == 0) iMask = 4'($urandom);
      iDwell = 8'($urandom_range(0, 4));
      iMode = 1'($urandom);
      if (i % 700 == 350) begin
        #2 iRST_N = 0;
        model_reset();
        #1 chk("rand_arst_busy", oBusy, 0);
        cyc();
        #2 iRST_N = 1;
      end
      cyc();
    end
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
